// File: rtl/conv_pkg.sv
// Shared types, legal feature-map sizes and signed int8 helpers for the
// convolution pipeline stages.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pool_state_t;

    localparam logic [5:0] FLEN_8  = 6'd8;
    localparam logic [5:0] FLEN_16 = 6'd16;
    localparam logic [5:0] FLEN_24 = 6'd24;
    localparam logic [5:0] FLEN_32 = 6'd32;

    // One line-buffer entry per input word of an even row (Flen/4, max 8).
    localparam int LB_DEPTH = 8;
    localparam int LB_AW    = 3;

    function automatic logic flen_legal(input logic [5:0] f);
        return (f == FLEN_8) || (f == FLEN_16) || (f == FLEN_24) || (f == FLEN_32);
    endfunction

    function automatic logic [7:0] max_s8(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [7:0] relu_s8(input logic [7:0] a, input logic en);
        return (en && a[7]) ? 8'd0 : a;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Holds the horizontal maxima of the last even row, one 16-bit pair per
// input word; written on even rows, read combinationally on odd rows.
module pool_linebuf
    import conv_pkg::*;
#(
    parameter int DEPTH = LB_DEPTH,
    parameter int AW    = LB_AW
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [15:0]   o_rd_data
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pool_relu_stage.sv
// 2x2 signed max-pool with optional ReLU between the conv stage stream and
// the next stage; four int8 pixels in per word, four pooled pixels out.
module pool_relu_stage
    import conv_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic                                  S_AXIS_TUSER,
    input  logic                                  S_AXIS_TLAST,
    input  logic                                  S_AXIS_TVALID,
    output logic                                  S_AXIS_TREADY,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
    output logic                                  M_AXIS_TUSER,
    output logic                                  M_AXIS_TLAST,
    output logic                                  M_AXIS_TVALID,
    input  logic                                  M_AXIS_TREADY,
    input  logic [5:0]                            Flen,
    input  logic [8:0]                            num_OUTCH,
    input  logic                                  relu_en,
    input  logic                                  pool_start,
    output logic                                  pool_done,
    output logic                                  busy,
    output logic                                  last_err
);

    pool_state_t r_state;
    pool_state_t w_state_next;

    logic [5:0]  r_flen;
    logic [8:0]  r_nch;
    logic        r_relu;
    logic [2:0]  r_col;
    logic [4:0]  r_row;
    logic [8:0]  r_ch;
    logic        r_in_done;
    logic        r_last_err;

    logic [15:0] r_lo;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_user;
    logic        r_out_last;

    logic [2:0]  w_col_max;
    logic [4:0]  w_row_max;
    logic [8:0]  w_ch_max;
    logic        w_col_end;
    logic        w_row_end;
    logic        w_final_in;
    logic        w_odd_row;
    logic        w_completes;
    logic        w_out_fire;
    logic        w_s_ready;
    logic        w_in_fire;
    logic        w_load;
    logic [15:0] w_h_pair;
    logic [15:0] w_lb_rd;
    logic [15:0] w_pool_pair;
    logic        w_unused;

    // Sideband of the input stream carries nothing this stage needs.
    assign w_unused = ^{S_AXIS_TKEEP, S_AXIS_TUSER};

    assign w_col_max  = 3'(r_flen[5:2] - 4'd1);
    assign w_row_max  = 5'(r_flen - 6'd1);
    assign w_ch_max   = 9'(r_nch - 9'd1);
    assign w_col_end  = (r_col == w_col_max);
    assign w_row_end  = (r_row == w_row_max);
    assign w_final_in = w_col_end && w_row_end && (r_ch == w_ch_max);
    assign w_odd_row  = r_row[0];
    assign w_completes = w_odd_row && r_col[0];

    assign w_out_fire = r_out_valid && M_AXIS_TREADY;
    // Stall only the word that would overwrite an undrained output word.
    assign w_s_ready  = (r_state == ST_RUN) && !r_in_done &&
                        !(w_completes && r_out_valid && !M_AXIS_TREADY);
    assign w_in_fire  = S_AXIS_TVALID && w_s_ready;
    assign w_load     = w_in_fire && w_completes;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign w_h_pair[8*gi +: 8] =
                max_s8(S_AXIS_TDATA[16*gi +: 8], S_AXIS_TDATA[16*gi+8 +: 8]);
            assign w_pool_pair[8*gi +: 8] =
                relu_s8(max_s8(w_h_pair[8*gi +: 8], w_lb_rd[8*gi +: 8]), r_relu);
        end
    endgenerate

    pool_linebuf #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW)
    ) u_linebuf (
        .clk       (CLK),
        .i_wr_en   (w_in_fire && !w_odd_row),
        .i_wr_addr (r_col),
        .i_wr_data (w_h_pair),
        .i_rd_addr (r_col),
        .o_rd_data (w_lb_rd)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (pool_start) w_state_next = ST_RUN;
            ST_RUN: begin
                if ((r_nch == 9'd0) || (w_out_fire && r_out_last)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_flen     <= FLEN_8;
            r_nch      <= 9'd0;
            r_relu     <= 1'b0;
            r_col      <= 3'd0;
            r_row      <= 5'd0;
            r_ch       <= 9'd0;
            r_in_done  <= 1'b0;
            r_last_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && pool_start) begin
                // Illegal sizes are coerced so the counters stay bounded.
                r_flen     <= flen_legal(Flen) ? Flen : FLEN_8;
                r_nch      <= num_OUTCH;
                r_relu     <= relu_en;
                r_col      <= 3'd0;
                r_row      <= 5'd0;
                r_ch       <= 9'd0;
                r_last_err <= 1'b0;
                r_in_done  <= (num_OUTCH == 9'd0);
            end else if (w_in_fire) begin
                if (S_AXIS_TLAST != w_final_in) begin
                    r_last_err <= 1'b1;
                end
                if (w_final_in) begin
                    r_in_done <= 1'b1;
                end
                if (w_col_end) begin
                    r_col <= 3'd0;
                    if (w_row_end) begin
                        r_row <= 5'd0;
                        r_ch  <= r_ch + 9'd1;
                    end else begin
                        r_row <= r_row + 5'd1;
                    end
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_in_fire && w_odd_row && !r_col[0]) begin
            r_lo <= w_pool_pair;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_user  <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            // A reload in the drain cycle wins, giving back-to-back words.
            if (w_load) begin
                r_out_data  <= {w_pool_pair, r_lo};
                r_out_valid <= 1'b1;
                r_out_user  <= (r_row == 5'd1) && (r_col == 3'd1);
                r_out_last  <= w_final_in;
            end
        end
    end

    assign S_AXIS_TREADY = w_s_ready;
    assign M_AXIS_TDATA  = r_out_data;
    assign M_AXIS_TKEEP  = {(C_S00_AXIS_TDATA_WIDTH/8){1'b1}};
    assign M_AXIS_TUSER  = r_out_user;
    assign M_AXIS_TLAST  = r_out_last;
    assign M_AXIS_TVALID = r_out_valid;
    assign pool_done     = (r_state == ST_DONE);
    assign busy          = (r_state != ST_IDLE);
    assign last_err      = r_last_err;

endmodule

// File: tb/tb_pool_relu_stage.sv
// Self-checking bench for pool_relu_stage: table of frame configurations,
// reference 2x2 pool model feeding a scoreboard, plus reset and empty-frame cases.
module tb_pool_relu_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] S_AXIS_TDATA = 32'd0;
    logic [3:0]  S_AXIS_TKEEP = 4'hF;
    logic        S_AXIS_TUSER = 1'b0;
    logic        S_AXIS_TLAST = 1'b0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TUSER;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b0;
    logic [5:0]  Flen = 6'd8;
    logic [8:0]  num_OUTCH = 9'd0;
    logic        relu_en = 1'b0;
    logic        pool_start = 1'b0;
    logic        pool_done;
    logic        busy;
    logic        last_err;

    always #5 CLK = ~CLK;

    pool_relu_stage #(.C_S00_AXIS_TDATA_WIDTH(32)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .Flen          (Flen),
        .num_OUTCH     (num_OUTCH),
        .relu_en       (relu_en),
        .pool_start    (pool_start),
        .pool_done     (pool_done),
        .busy          (busy),
        .last_err      (last_err)
    );

    // pat: 0 ramp 8*r+c+16*ch, 1 all -5, 2 random
    // rdy: 0 always, 1 toggle, 2 random; tl: 0 normal, 1 extra on word 7, 2 missing on final
    typedef struct {
        int          flen;
        int          nch;
        bit          relu;
        int          pat;
        int          rdy;
        int          gap;
        int          tl;
        bit          chk;
        logic [31:0] first;
        bit          err;
        int          words;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } exp_t;

    vec_t        vecs [9];
    exp_t        sb [$];
    logic [7:0]  img [0:4095];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cur_frame = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s frame %0d: got %h expected %h", name, cur_frame, act, exp);
    endtask

    function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    task automatic fill_image(input vec_t v);
        int f = v.flen;
        for (int i = 0; i < v.nch * f * f; i++) begin
            int c = i % f;
            int r = (i / f) % f;
            int ch = i / (f * f);
            case (v.pat)
                0:       img[i] = 8'(8 * r + c + 16 * ch);
                1:       img[i] = 8'hFB;
                default: img[i] = 8'($urandom);
            endcase
        end
    endtask

    // Reference: each output byte is the signed max of a full 2x2 window.
    task automatic build_expected(input vec_t v);
        int f = v.flen;
        for (int ch = 0; ch < v.nch; ch++) begin
            for (int i = 0; i < f / 2; i++) begin
                for (int k = 0; k < f / 8; k++) begin
                    exp_t e;
                    logic [31:0] w;
                    w = 32'd0;
                    for (int b = 0; b < 4; b++) begin
                        int base = (ch * f + 2 * i) * f + 2 * (4 * k + b);
                        logic [7:0] a;
                        a = smax(smax(img[base], img[base + 1]),
                                 smax(img[base + f], img[base + f + 1]));
                        if (v.relu && a[7]) a = 8'd0;
                        w[8 * b +: 8] = a;
                    end
                    e.data = w;
                    e.user = (i == 0) && (k == 0);
                    e.last = (ch == v.nch - 1) && (i == f / 2 - 1) && (k == f / 8 - 1);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic run_frame(input vec_t v, input int stop_after);
        int   total = v.nch * v.flen * v.flen / 4;
        int   in_idx = 0;
        int   out_cnt = 0;
        int   cyc = 0;
        int   last_hs = -10;
        int   done_cyc = -1;
        bit   hold = 1'b0;
        exp_t e;
        @(negedge CLK);
        Flen = 6'(v.flen);
        num_OUTCH = 9'(v.nch);
        relu_en = v.relu;
        pool_start = 1'b1;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b0;
        @(negedge CLK);
        pool_start = 1'b0;
        while (cyc < 20000) begin
            if (stop_after >= 0 && in_idx >= stop_after) break;
            if (!hold) S_AXIS_TVALID = (in_idx < total) && (v.gap == 0 || $urandom_range(0, 3) != 0);
            if (S_AXIS_TVALID) begin
                S_AXIS_TDATA = {img[4*in_idx+3], img[4*in_idx+2], img[4*in_idx+1], img[4*in_idx]};
                case (v.tl)
                    0:       S_AXIS_TLAST = (in_idx == total - 1);
                    1:       S_AXIS_TLAST = (in_idx == total - 1) || (in_idx == 7);
                    default: S_AXIS_TLAST = 1'b0;
                endcase
            end
            case (v.rdy)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = (cyc % 2 == 0);
                default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            endcase
            #4;
            hold = S_AXIS_TVALID && !S_AXIS_TREADY;
            if (S_AXIS_TVALID && S_AXIS_TREADY) in_idx++;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                $display("frame %0d word %0d data=%h user=%b last=%b", cur_frame, out_cnt,
                         M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST);
                if (sb.size() == 0) begin
                    check("unexpected_word", 32'(out_cnt), 32'(v.words));
                end else begin
                    e = sb.pop_front();
                    check("data", M_AXIS_TDATA, e.data);
                    check("user_last", 32'({M_AXIS_TUSER, M_AXIS_TLAST}), 32'({e.user, e.last}));
                    check("keep", 32'(M_AXIS_TKEEP), 32'hF);
                end
                if (out_cnt == 0 && v.chk) check("first_word", M_AXIS_TDATA, v.first);
                if (M_AXIS_TLAST) last_hs = cyc;
                out_cnt++;
            end
            if (pool_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge CLK);
            cyc++;
        end
        if (stop_after < 0) begin
            check("done_seen", 32'(done_cyc >= 0), 32'd1);
            check("done_timing", 32'(done_cyc), 32'(last_hs + 1));
            check("word_count", 32'(out_cnt), 32'(v.words));
            check("sb_empty", 32'(sb.size()), 32'd0);
            check("last_err", 32'(last_err), 32'(v.err));
            @(negedge CLK);
            S_AXIS_TVALID = 1'b0;
            #4;
            check("busy_after_done", 32'(busy), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int done_k;
        int done_n;
        vecs[0] = '{8,  1, 1'b0, 0, 0, 0, 0, 1'b1, 32'h0F0D0B09, 1'b0, 4};
        vecs[1] = '{8,  1, 1'b1, 1, 0, 0, 0, 1'b1, 32'h00000000, 1'b0, 4};
        vecs[2] = '{8,  1, 1'b0, 1, 0, 0, 0, 1'b1, 32'hFBFBFBFB, 1'b0, 4};
        vecs[3] = '{16, 2, 1'b0, 0, 1, 0, 0, 1'b1, 32'h0F0D0B09, 1'b0, 32};
        vecs[4] = '{8,  1, 1'b0, 0, 0, 0, 1, 1'b1, 32'h0F0D0B09, 1'b1, 4};
        vecs[5] = '{8,  1, 1'b0, 0, 0, 0, 2, 1'b1, 32'h0F0D0B09, 1'b1, 4};
        vecs[6] = '{24, 1, 1'b1, 2, 2, 1, 0, 1'b0, 32'h0,        1'b0, 36};
        vecs[7] = '{32, 1, 1'b0, 2, 2, 1, 0, 1'b0, 32'h0,        1'b0, 64};
        vecs[8] = '{16, 3, 1'b1, 2, 1, 1, 0, 1'b0, 32'h0,        1'b0, 48};

        repeat (3) @(negedge CLK);
        #4;
        check("rst_mvalid", 32'(M_AXIS_TVALID), 32'd0);
        check("rst_sready", 32'(S_AXIS_TREADY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(pool_done), 32'd0);
        check("rst_err", 32'(last_err), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int t = 0; t < 9; t++) begin
            cur_frame = t;
            fill_image(vecs[t]);
            build_expected(vecs[t]);
            run_frame(vecs[t], -1);
        end

        // Empty frame: straight through RUN to DONE with no stream traffic.
        cur_frame = 100;
        @(negedge CLK);
        Flen = 6'd8;
        num_OUTCH = 9'd0;
        pool_start = 1'b1;
        S_AXIS_TVALID = 1'b1;
        M_AXIS_TREADY = 1'b1;
        done_k = -1;
        done_n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            pool_start = 1'b0;
            #4;
            check("n0_sready", 32'(S_AXIS_TREADY), 32'd0);
            check("n0_mvalid", 32'(M_AXIS_TVALID), 32'd0);
            if (pool_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == 2) check("n0_busy_after", 32'(busy), 32'd0);
        end
        check("n0_done_cycle", 32'(done_k), 32'd1);
        check("n0_done_pulses", 32'(done_n), 32'd1);
        S_AXIS_TVALID = 1'b0;

        // Mid-frame reset, then a clean full frame.
        cur_frame = 200;
        fill_image(vecs[0]);
        build_expected(vecs[0]);
        run_frame(vecs[0], 10);
        S_AXIS_TVALID = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_mvalid", 32'(M_AXIS_TVALID), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sready", 32'(S_AXIS_TREADY), 32'd0);
        check("mid_rst_err", 32'(last_err), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        cur_frame = 201;
        build_expected(vecs[0]);
        run_frame(vecs[0], -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_relu_stage.md
POOL_RELU_STAGE -- requirements
Module: pool_relu_stage

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32, stream word width; only 32 is supported.
REQ-002 SHALL have port CLK, input, 1, the single clock.
REQ-003 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports S_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID (inputs, 32/4/1/1/1) and S_AXIS_TREADY (output, 1), fed by the conv stage master stream.
REQ-005 SHALL have ports M_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID (outputs, 32/4/1/1/1) and M_AXIS_TREADY (input, 1), the pooled output stream.
REQ-006 SHALL have inputs Flen (6) feature-map side length, num_OUTCH (9) channel count, relu_en (1) ReLU enable, pool_start (1) single-cycle start pulse.
REQ-007 SHALL have outputs pool_done (1) single-cycle completion pulse, busy (1) high outside IDLE, last_err (1) sticky TLAST-mismatch flag.

Function
REQ-008 Input word SHALL be 4 signed int8 pixels of one row, byte 0 = leftmost; rows are streamed top to bottom, channel after channel.
REQ-009 Legal Flen SHALL be 8, 16, 24 or 32; words per row W = Flen/4; other values give undefined output.
REQ-010 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on pool_start, RUN->DONE after the final output handshake, DONE->IDLE after one cycle.
REQ-011 pool_start in IDLE SHALL latch Flen, num_OUTCH and relu_en and clear col, row and channel counters and last_err; pool_start outside IDLE SHALL be ignored.
REQ-012 Each accepted input word SHALL yield horizontal maxima h0 = max(b0,b1) and h1 = max(b2,b3), signed compare.
REQ-013 On even rows, {h1,h0} SHALL be written to a W-entry x 16-bit line buffer at index col.
REQ-014 On odd rows, pooled bytes p0 = max(h0, linebuf[col].lo) and p1 = max(h1, linebuf[col].hi) SHALL be formed; with relu_en=1, negative results SHALL become 0.
REQ-015 Pooled pairs SHALL be packed: even col fills output bytes 1:0, odd col fills bytes 3:2 and loads the output register; one output word per two odd-row input words.
REQ-016 Output register SHALL be a single entry; M_AXIS_TVALID high while loaded; it clears on M_AXIS_TVALID & M_AXIS_TREADY.
REQ-017 S_AXIS_TREADY SHALL be 1 in RUN except when the current word completes an output word while the output register is loaded and M_AXIS_TREADY=0; 0 in IDLE and DONE.
REQ-018 Simultaneous output drain and reload in the same cycle SHALL be permitted, sustaining one word per cycle with no bubble.
REQ-019 M_AXIS_TKEEP SHALL be 4'hF; M_AXIS_TUSER SHALL be 1 on the first output word of each channel, else 0.
REQ-020 M_AXIS_TLAST SHALL be 1 only on the final output word of the final channel.
REQ-021 Counters SHALL wrap col at W-1, row at Flen-1 (then channel++); the final input is channel num_OUTCH-1, row Flen-1, col W-1.
REQ-022 last_err SHALL be set if S_AXIS_TLAST is seen on a non-final input word, or is absent on the final one; processing SHALL continue regardless.
REQ-023 num_OUTCH=0 SHALL go IDLE->RUN->DONE with pool_done and no stream activity.
REQ-024 pool_done SHALL pulse in DONE, exactly one cycle after the final output handshake.
REQ-025 Output words per channel SHALL be Flen*Flen/16; input words per channel Flen*Flen/4.

Reset
REQ-026 RESET SHALL return the FSM to IDLE, clear counters, the output register, last_err, pool_done and busy, and drive S_AXIS_TREADY=0 and M_AXIS_TVALID=0, mid-frame included.
REQ-027 Line buffer contents SHALL NOT require reset; they SHALL never be read before being written in a frame.

Structure
REQ-028 State encoding, legal-Flen constants and the signed int8 max function SHALL live in shared package conv_pkg.
REQ-029 Line buffer SHALL be a sub-module pool_linebuf (W-deep, 16-bit, 1 write/1 read, combinational read).

Verification
REQ-030 Flen=8, num_OUTCH=1, relu_en=0, rows r filled with pixel value 8*r+col -> 4 output words, first = 0x1B19_1513? No: pooled value = 8*(2i+1)+(2j+1); first word bytes {15,13,11,9}.
REQ-031 Flen=8, all pixels -5, relu_en=1 -> 4 words of 0x00000000; relu_en=0 -> 4 words of 0xFBFBFBFB.
REQ-032 Flen=16, num_OUTCH=2, M_AXIS_TREADY toggled 1/0 each cycle -> 32 words, no loss or duplicate, TUSER on words 0 and 16, TLAST on word 31 only.
REQ-033 Flen=8, num_OUTCH=1, S_AXIS_TLAST asserted on input word 7 -> last_err=1, all 4 outputs still produced, pool_done pulses.
REQ-034 RESET asserted after 10 input words -> next cycle M_AXIS_TVALID=0, busy=0; new pool_start then completes a full frame correctly.
REQ-035 num_OUTCH=0 -> pool_done 2 cycles after pool_start, S_AXIS_TREADY and M_AXIS_TVALID stay 0.
